seq_addmul_unit: RTL



---
 rtl/seq_addmul_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_addmul_unit.sv
// ============================================================================
// seq_addmul_unit : handshaked unsigned add (1 cycle) / shift-add multiply
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_addmul_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [2*WIDTH-1:0] result_q, result_nxt;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     add_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      count    <= count_nxt;
      result_q <= result_nxt;
    end
  end

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    count_nxt  = count;
    result_nxt = result_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (op) begin
            result_nxt = {{(WIDTH-1){1'b0}}, add_sum};
            state_nxt  = DONE;
          end else begin
            mcand_nxt  = {{WIDTH{1'b0}}, a};
            mplier_nxt = b;
            acc_nxt    = '0;
            count_nxt  = '0;
            state_nxt  = MUL;
          end
        end
      end
      MUL: begin
        acc_nxt    = acc_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + CNT_W'(1);
        // Fixed WIDTH iterations; no early exit when the multiplier runs out.
        if (count == CNT_W'(WIDTH - 1)) begin
          result_nxt = acc_step;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DONE);
  assign result    = result_q;

endmodule

`default_nettype wire
